// File: rtl/virtual_ds2431_byte_seq_tx.sv
// virtual_ds2431_byte_seq_tx: streams a byte window of a snapshot vector to the 1-Wire byte transceiver
// Ports: clk/rst (sync, active-high); txData source bytes (byte k = txData[8k+7:8k]);
//   startIdx/byteCount select the window at start; cmdRunTrig rising edge starts/restarts;
//   abort level cancels; ByteTransDone rising edge acks a byte; sentDat/transTrig drive the
//   transceiver; nRxTx fixed to transmit; cmdDone/busy/bytesSent report progress.
// Optional: define VDS2431_SEQ_CRC8_EN to append a Dallas CRC8 byte after the data bytes.
module virtual_ds2431_byte_seq_tx #(
  parameter int DATA_BYTES = 8,
  parameter int IDX_W = 3,
  parameter logic [7:0] IDLE_DAT = 8'hFF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*DATA_BYTES-1:0] txData,
  input  logic [IDX_W-1:0]        startIdx,
  input  logic [IDX_W:0]          byteCount,
  input  logic                    cmdRunTrig,
  input  logic                    abort,
  input  logic                    ByteTransDone,
  output logic [7:0]              sentDat,
  output logic                    transTrig,
  output logic                    nRxTx,
  output logic                    cmdDone,
  output logic                    busy,
  output logic [IDX_W:0]          bytesSent
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT, S_DONE
`ifdef VDS2431_SEQ_CRC8_EN
    , S_CRC_LOAD, S_CRC_WAIT
`endif
  } state_t;
`ifdef VDS2431_SEQ_CRC8_EN
  localparam state_t LP_AFTER = S_CRC_LOAD;
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 8'h8C) : (r >> 1);
    return r;
  endfunction
  logic [7:0] r_crc, w_crc;
`else
  localparam state_t LP_AFTER = S_DONE;
`endif
  localparam logic [IDX_W:0] LP_NB = (IDX_W+1)'(DATA_BYTES);
  localparam logic [IDX_W:0] LP_ONE = (IDX_W+1)'(1);
  state_t r_state, w_state;
  logic [8*DATA_BYTES-1:0] r_snap, w_snap;
  logic [IDX_W-1:0] r_idx, w_idx;
  logic [IDX_W:0] r_rem, w_rem, r_sent, w_sent, w_avail, w_eff;
  logic [7:0] r_dat, w_dat, w_byte;
  logic r_trig, w_trig, r_done, w_done, r_busy, w_busy;
  logic r_cmd_prev, r_btd_prev, w_start, w_btd;
  assign w_start = cmdRunTrig & ~r_cmd_prev;
  assign w_btd = ByteTransDone & ~r_btd_prev;
  assign w_avail = LP_NB - {1'b0, startIdx};
  // Windows that run past the end are clamped, never wrapped.
  assign w_eff = ({1'b0, startIdx} >= LP_NB) ? '0 : (byteCount < w_avail ? byteCount : w_avail);
  assign w_byte = 8'(r_snap >> {r_idx, 3'b000});
  always_comb begin
    w_state = r_state;
    w_snap = r_snap;
    w_idx = r_idx;
    w_rem = r_rem;
    w_sent = r_sent;
    w_dat = r_dat;
    w_trig = 1'b0;
    w_done = r_done;
    w_busy = r_busy;
`ifdef VDS2431_SEQ_CRC8_EN
    w_crc = r_crc;
`endif
    if (abort) begin
      w_state = S_IDLE;
      w_busy = 1'b0;
      w_done = 1'b0;
      w_dat = IDLE_DAT;
    end else if (w_start) begin
      // A restart drops any in-flight byte; a coincident ack edge is ignored.
      w_snap = txData;
      w_idx = startIdx;
      w_rem = w_eff;
      w_sent = '0;
      w_done = 1'b0;
      w_busy = 1'b1;
`ifdef VDS2431_SEQ_CRC8_EN
      w_crc = 8'h00;
`endif
      w_state = (w_eff != '0) ? S_LOAD : LP_AFTER;
    end else begin
      case (r_state)
        S_IDLE: w_dat = IDLE_DAT;
        S_LOAD: begin
          w_dat = w_byte;
          w_trig = 1'b1;
          w_state = S_WAIT;
        end
        S_WAIT: if (w_btd) begin
          w_idx = r_idx + 1'b1;
          w_rem = r_rem - LP_ONE;
          w_sent = r_sent + LP_ONE;
`ifdef VDS2431_SEQ_CRC8_EN
          w_crc = crc8(r_crc, r_dat);
`endif
          w_state = (r_rem > LP_ONE) ? S_LOAD : LP_AFTER;
        end
`ifdef VDS2431_SEQ_CRC8_EN
        S_CRC_LOAD: begin
          w_dat = r_crc;
          w_trig = 1'b1;
          w_state = S_CRC_WAIT;
        end
        S_CRC_WAIT: w_state = w_btd ? S_DONE : S_CRC_WAIT;
`endif
        S_DONE: begin
          w_done = 1'b1;
          w_busy = 1'b0;
          w_dat = IDLE_DAT;
          w_state = S_IDLE;
        end
        default: w_state = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_snap <= '0;
      r_idx <= '0;
      r_rem <= '0;
      r_sent <= '0;
      r_dat <= IDLE_DAT;
      r_trig <= 1'b0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
      r_cmd_prev <= 1'b0;
      r_btd_prev <= 1'b0;
    end else begin
      r_state <= w_state;
      r_snap <= w_snap;
      r_idx <= w_idx;
      r_rem <= w_rem;
      r_sent <= w_sent;
      r_dat <= w_dat;
      r_trig <= w_trig;
      r_done <= w_done;
      r_busy <= w_busy;
      r_cmd_prev <= cmdRunTrig;
      r_btd_prev <= ByteTransDone;
    end
  end
`ifdef VDS2431_SEQ_CRC8_EN
  always_ff @(posedge clk) r_crc <= rst ? 8'h00 : w_crc;
`endif
  assign sentDat = r_dat;
  assign transTrig = r_trig;
  assign nRxTx = 1'b1;
  assign cmdDone = r_done;
  assign busy = r_busy;
  assign bytesSent = r_sent;
endmodule

// File: tb/tb_virtual_ds2431_byte_seq_tx.sv
// tb_virtual_ds2431_byte_seq_tx: scoreboard bench for the DS2431 byte sequencer
module tb_virtual_ds2431_byte_seq_tx;
  localparam int NB = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [63:0] txData = '0;
  logic [2:0] startIdx = '0;
  logic [3:0] byteCount = '0;
  logic cmdRunTrig = 1'b0, abort = 1'b0, ByteTransDone = 1'b0;
  logic [7:0] sentDat;
  logic transTrig, nRxTx, cmdDone, busy;
  logic [3:0] bytesSent;
  logic [3:0] startIdx2 = '0;
  logic [4:0] byteCount2 = '0;
  logic cmdRunTrig2 = 1'b0, ByteTransDone2 = 1'b0;
  logic [7:0] sentDat2;
  logic transTrig2, nRxTx2, cmdDone2, busy2;
  logic [4:0] bytesSent2;
  int checks = 0, errors = 0, trig_count = 0, trig2_count = 0;
  logic [7:0] exp_q[$];

  virtual_ds2431_byte_seq_tx dut (
    .clk(clk), .rst(rst), .txData(txData), .startIdx(startIdx), .byteCount(byteCount),
    .cmdRunTrig(cmdRunTrig), .abort(abort), .ByteTransDone(ByteTransDone), .sentDat(sentDat),
    .transTrig(transTrig), .nRxTx(nRxTx), .cmdDone(cmdDone), .busy(busy), .bytesSent(bytesSent)
  );
  virtual_ds2431_byte_seq_tx #(.DATA_BYTES(8), .IDX_W(4)) dut2 (
    .clk(clk), .rst(rst), .txData(txData), .startIdx(startIdx2), .byteCount(byteCount2),
    .cmdRunTrig(cmdRunTrig2), .abort(abort), .ByteTransDone(ByteTransDone2), .sentDat(sentDat2),
    .transTrig(transTrig2), .nRxTx(nRxTx2), .cmdDone(cmdDone2), .busy(busy2), .bytesSent(bytesSent2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin : mon
    logic [7:0] e;
    if (transTrig) begin
      trig_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte got %02h expected none", sentDat);
      end else begin
        e = exp_q.pop_front();
        if (sentDat !== e) begin
          errors++;
          $display("FAIL byte_seq got %02h expected %02h", sentDat, e);
        end
      end
    end
    if (transTrig2) trig2_count++;
  end

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 8'h8C;
      else r = r >> 1;
    end
    return r;
  endfunction

  task automatic push_expected(input logic [63:0] d, input int idx, input int cnt, output int n);
    int eff;
    logic [7:0] c, b;
    eff = (idx >= NB) ? 0 : ((cnt < NB - idx) ? cnt : NB - idx);
    c = 8'h00;
    for (int k = 0; k < eff; k++) begin
      b = d[8*(idx+k) +: 8];
      exp_q.push_back(b);
      c = crc8(c, b);
    end
    n = eff;
`ifdef VDS2431_SEQ_CRC8_EN
    exp_q.push_back(c);
    n = eff + 1;
`endif
  endtask

  task automatic start_cmd(input logic [63:0] d, input int idx, input int cnt);
    @(negedge clk);
    txData = d;
    startIdx = 3'(idx);
    byteCount = 4'(cnt);
    cmdRunTrig = 1'b1;
    @(negedge clk);
    cmdRunTrig = 1'b0;
  endtask

  task automatic wait_trig(output int lat);
    lat = 0;
    for (int i = 1; i <= 30 && lat == 0; i++) begin
      @(negedge clk);
      if (transTrig) lat = i;
    end
  endtask

  task automatic ack_byte(output int lat);
    wait_trig(lat);
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL trig_timeout got none expected transTrig within 30 clocks");
    end else begin
      @(negedge clk);
      ByteTransDone = 1'b1;
      @(negedge clk);
      ByteTransDone = 1'b0;
    end
  endtask

  task automatic send_all(input int n);
    int lat;
    for (int k = 0; k < n; k++) ack_byte(lat);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (sentDat !== 8'hFF) begin errors++; $display("FAIL rst_sentDat got %02h expected ff", sentDat); end
    checks++; if (transTrig !== 1'b0) begin errors++; $display("FAIL rst_transTrig got %b expected 0", transTrig); end
    checks++; if (cmdDone !== 1'b0) begin errors++; $display("FAIL rst_cmdDone got %b expected 0", cmdDone); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b expected 0", busy); end
    checks++; if (bytesSent !== 4'd0) begin errors++; $display("FAIL rst_bytesSent got %0d expected 0", bytesSent); end
    checks++; if (nRxTx !== 1'b1) begin errors++; $display("FAIL rst_nRxTx got %b expected 1", nRxTx); end
    rst = 1'b0;
  endtask

  task automatic test_full_rom;
    int n, lat, base;
    base = trig_count;
    push_expected(64'h2D00_0000_1234_5678, 0, 8, n);
    start_cmd(64'h2D00_0000_1234_5678, 0, 8);
    checks++; if (busy !== 1'b1 || transTrig !== 1'b0) begin errors++; $display("FAIL full_start got busy=%b trig=%b expected busy=1 trig=0", busy, transTrig); end
    ack_byte(lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL full_latency got %0d expected 1 clock after start release", lat); end
    send_all(n - 1);
    repeat (3) @(negedge clk);
    checks++; if (cmdDone !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL full_done got done=%b busy=%b expected 1 0", cmdDone, busy); end
    checks++; if (bytesSent !== 4'd8) begin errors++; $display("FAIL full_bytesSent got %0d expected 8", bytesSent); end
    checks++; if (sentDat !== 8'hFF) begin errors++; $display("FAIL full_idle_dat got %02h expected ff", sentDat); end
    checks++; if (trig_count - base != n || exp_q.size() != 0) begin errors++; $display("FAIL full_trig_count got %0d expected %0d", trig_count - base, n); end
  endtask

  task automatic test_clamp;
    int n, base;
    base = trig_count;
    push_expected(64'h2D00_0000_1234_5678, 6, 5, n);
    start_cmd(64'h2D00_0000_1234_5678, 6, 5);
    send_all(n);
    repeat (3) @(negedge clk);
    checks++; if (bytesSent !== 4'd2) begin errors++; $display("FAIL clamp_bytesSent got %0d expected 2", bytesSent); end
    checks++; if (cmdDone !== 1'b1) begin errors++; $display("FAIL clamp_done got %b expected 1", cmdDone); end
    checks++; if (trig_count - base != n || exp_q.size() != 0) begin errors++; $display("FAIL clamp_trig_count got %0d expected %0d", trig_count - base, n); end
  endtask

  task automatic test_zero_len;
    int n, base, got, lat;
    base = trig_count;
    push_expected(64'h2D00_0000_1234_5678, 7, 0, n);
    start_cmd(64'h2D00_0000_1234_5678, 7, 0);
    got = 0;
`ifdef VDS2431_SEQ_CRC8_EN
    send_all(n);
    repeat (3) @(negedge clk);
    got = int'(cmdDone);
`else
    for (int i = 0; i < 3 && got == 0; i++) begin
      if (cmdDone) got = 1;
      else @(negedge clk);
    end
`endif
    checks++; if (got != 1) begin errors++; $display("FAIL zero_done got %b expected 1", cmdDone); end
    checks++; if (trig_count - base != n || exp_q.size() != 0) begin errors++; $display("FAIL zero_trig_count got %0d expected %0d", trig_count - base, n); end
    checks++; if (bytesSent !== 4'd0) begin errors++; $display("FAIL zero_bytesSent got %0d expected 0", bytesSent); end
    base = trig2_count;
    @(negedge clk);
    startIdx2 = 4'd9;
    byteCount2 = 5'd5;
    cmdRunTrig2 = 1'b1;
    @(negedge clk);
    cmdRunTrig2 = 1'b0;
    got = 0;
`ifdef VDS2431_SEQ_CRC8_EN
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      if (transTrig2) lat = i;
    end
    checks++; if (lat == 0 || sentDat2 !== 8'h00) begin errors++; $display("FAIL oor_crc_byte got %02h trig_lat=%0d expected 00", sentDat2, lat); end
    @(negedge clk);
    ByteTransDone2 = 1'b1;
    @(negedge clk);
    ByteTransDone2 = 1'b0;
    repeat (3) @(negedge clk);
    got = int'(cmdDone2);
    checks++; if (trig2_count - base != 1) begin errors++; $display("FAIL oor_trig_count got %0d expected 1", trig2_count - base); end
`else
    lat = 0;
    for (int i = 0; i < 3 && got == 0; i++) begin
      if (cmdDone2) got = 1;
      else @(negedge clk);
    end
    checks++; if (trig2_count - base != lat) begin errors++; $display("FAIL oor_trig_count got %0d expected 0", trig2_count - base); end
`endif
    checks++; if (got != 1) begin errors++; $display("FAIL oor_done got %b expected 1", cmdDone2); end
  endtask

`ifdef VDS2431_SEQ_CRC8_EN
  task automatic test_crc;
    int base;
    base = trig_count;
    exp_q.push_back(8'h02); exp_q.push_back(8'h1C); exp_q.push_back(8'hB8); exp_q.push_back(8'h01);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'hA2);
    start_cmd(64'hA200_0000_01B8_1C02, 0, 7);
    send_all(8);
    repeat (3) @(negedge clk);
    checks++; if (bytesSent !== 4'd7) begin errors++; $display("FAIL crc_bytesSent got %0d expected 7", bytesSent); end
    checks++; if (cmdDone !== 1'b1 || trig_count - base != 8) begin errors++; $display("FAIL crc_done got done=%b trigs=%0d expected 1 8", cmdDone, trig_count - base); end
  endtask
`endif

  task automatic test_abort;
    int n, lat, base;
    base = trig_count;
    push_expected(64'h2D00_0000_1234_5678, 0, 8, n);
    start_cmd(64'h2D00_0000_1234_5678, 0, 8);
    for (int k = 0; k < 3; k++) ack_byte(lat);
    abort = 1'b1;
    exp_q.delete();
    repeat (4) @(negedge clk);
    checks++; if (trig_count - base != 3) begin errors++; $display("FAIL abort_trig_count got %0d expected 3", trig_count - base); end
    checks++; if (busy !== 1'b0 || cmdDone !== 1'b0) begin errors++; $display("FAIL abort_status got busy=%b done=%b expected 0 0", busy, cmdDone); end
    checks++; if (bytesSent !== 4'd3) begin errors++; $display("FAIL abort_bytesSent got %0d expected 3", bytesSent); end
    checks++; if (sentDat !== 8'hFF) begin errors++; $display("FAIL abort_sentDat got %02h expected ff", sentDat); end
    abort = 1'b0;
    base = trig_count;
    push_expected(64'h0123_4567_89AB_CDEF, 0, 8, n);
    start_cmd(64'h0123_4567_89AB_CDEF, 0, 8);
    send_all(n);
    repeat (3) @(negedge clk);
    checks++; if (bytesSent !== 4'd8 || cmdDone !== 1'b1) begin errors++; $display("FAIL abort_restart got sent=%0d done=%b expected 8 1", bytesSent, cmdDone); end
    checks++; if (trig_count - base != n || exp_q.size() != 0) begin errors++; $display("FAIL abort_restart_trigs got %0d expected %0d", trig_count - base, n); end
  endtask

  task automatic test_back_to_back;
    int n, n2, lat, base;
    base = trig_count;
    push_expected(64'h2D00_0000_1234_5678, 0, 8, n);
    start_cmd(64'h2D00_0000_1234_5678, 0, 8);
    for (int k = 0; k < 2; k++) ack_byte(lat);
    wait_trig(lat);
    @(negedge clk);
    exp_q.delete();
    push_expected(64'hF0E1_D2C3_B4A5_9687, 4, 3, n2);
    txData = 64'hF0E1_D2C3_B4A5_9687;
    startIdx = 3'd4;
    byteCount = 4'd3;
    cmdRunTrig = 1'b1;
    ByteTransDone = 1'b1;
    @(negedge clk);
    cmdRunTrig = 1'b0;
    ByteTransDone = 1'b0;
    checks++; if (bytesSent !== 4'd0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_restart got sent=%0d busy=%b expected 0 1", bytesSent, busy); end
    send_all(n2);
    repeat (3) @(negedge clk);
    checks++; if (bytesSent !== 4'd3 || cmdDone !== 1'b1) begin errors++; $display("FAIL b2b_done got sent=%0d done=%b expected 3 1", bytesSent, cmdDone); end
    checks++; if (trig_count - base != 3 + n2 || exp_q.size() != 0) begin errors++; $display("FAIL b2b_trigs got %0d expected %0d", trig_count - base, 3 + n2); end
  endtask

  task automatic test_rst_mid_wait;
    int n, lat;
    push_expected(64'h2D00_0000_1234_5678, 0, 8, n);
    start_cmd(64'h2D00_0000_1234_5678, 0, 8);
    ack_byte(lat);
    wait_trig(lat);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (sentDat !== 8'hFF || transTrig !== 1'b0) begin errors++; $display("FAIL rstw_dat got %02h trig=%b expected ff 0", sentDat, transTrig); end
    checks++; if (busy !== 1'b0 || cmdDone !== 1'b0) begin errors++; $display("FAIL rstw_status got busy=%b done=%b expected 0 0", busy, cmdDone); end
    checks++; if (bytesSent !== 4'd0) begin errors++; $display("FAIL rstw_bytesSent got %0d expected 0", bytesSent); end
    rst = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_rom();
    test_clamp();
    test_zero_len();
`ifdef VDS2431_SEQ_CRC8_EN
    test_crc();
`endif
    test_abort();
    test_back_to_back();
    test_rst_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/virtual_ds2431_byte_seq_tx.md
Name: virtual_ds2431_byte_seq_tx

Overview:
Parametrised multi-byte transmit sequencer for the virtual DS2431 1-Wire slave. It streams a window of bytes from a snapshot data vector, LSB byte first, to the byte-level transceiver using the transTrig/ByteTransDone handshake. It replaces fixed 8-byte ROM responders and serves READ ROM, scratchpad and memory read-back responses. It adds a selectable start index and length, abort, progress status, and an optional appended Dallas CRC8.

Parameters:
DATA_BYTES, 8, number of bytes in txData.
IDX_W, 3, index width; must satisfy 2^IDX_W >= DATA_BYTES.
IDLE_DAT, 8'hFF, value driven on sentDat when not sending.

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous reset, active-high
txData  in  8*DATA_BYTES  source bytes; byte k = txData[8k+7:8k]
startIdx  in  IDX_W  first byte index; sampled at start
byteCount  in  IDX_W+1  number of bytes to send; sampled at start
cmdRunTrig  in  1  start request; rising edge starts or restarts a command
abort  in  1  level; cancels the current command
ByteTransDone  in  1  transceiver byte-complete; rising edge used
sentDat  out  8  byte presented to the transceiver
transTrig  out  1  one-clock pulse requesting transmission of sentDat
nRxTx  out  1  constant 1 (transmit direction)
cmdDone  out  1  high after normal completion; held until next start, abort or rst
busy  out  1  high while a command is in progress
bytesSent  out  IDX_W+1  data bytes acknowledged in the current command

Behaviour:
- Reset (rst=1 at posedge): state IDLE; sentDat=IDLE_DAT; transTrig=0; cmdDone=0; busy=0; bytesSent=0; edge-detect registers=0.
- Edge detection: internal prev-sample registers. An edge is (signal & ~prev) in the same cycle.
- States: IDLE, LOAD, WAIT, CRC_LOAD, CRC_WAIT, DONE.
- Start (cmdRunTrig edge, any state):
  - Snapshot txData, startIdx and byteCount. Set idx=startIdx, remaining=effective count, bytesSent=0, cmdDone=0, busy=1, CRC accumulator=0.
  - Effective count = 0 if startIdx >= DATA_BYTES, else min(byteCount, DATA_BYTES-startIdx). Overrun is clamped, never wrapped.
  - Next state is LOAD if the effective count is nonzero. Otherwise it is CRC_LOAD (CRC enabled) or DONE.
- LOAD (1 clock): sentDat <= snapshot byte[idx]; transTrig <= 1; next state WAIT.
  - transTrig is high for exactly one cycle, the first cycle in which sentDat holds the new byte.
  - First transTrig is visible 2 clocks after the cmdRunTrig edge is sampled.
- WAIT: sentDat is held and transTrig=0. On a ByteTransDone edge: idx+1, remaining-1, bytesSent+1, CRC updated with the sent byte. Next state is LOAD if remaining>1, else CRC_LOAD or DONE.
- A ByteTransDone edge outside WAIT/CRC_WAIT is ignored.
- DONE (1 clock): cmdDone <= 1, busy <= 0, sentDat <= IDLE_DAT; next state IDLE.
- IDLE: sentDat=IDLE_DAT, transTrig=0; cmdDone keeps its value.
- abort=1 at a posedge, any state: next state IDLE, busy=0, transTrig=0, sentDat=IDLE_DAT, cmdDone=0. bytesSent is frozen.
- Priority: rst > abort > cmdRunTrig edge > ByteTransDone edge.
- A restart while busy discards the in-flight byte and begins the new command from LOAD.
- Simultaneous ByteTransDone edge and cmdRunTrig edge: the start wins and the done edge is dropped.

Optional Feature:
Macro VDS2431_SEQ_CRC8_EN.
- Defined: after the data bytes, send one extra byte in CRC_LOAD/CRC_WAIT, with the same handshake as LOAD/WAIT.
  - The extra byte is the Dallas/Maxim CRC8 (poly x^8+x^5+x^4+1, reflected 0x8C, init 0x00, LSB-first) over the bytes actually sent.
  - bytesSent excludes the CRC byte. With an effective count of 0, CRC byte 0x00 is sent.
- Undefined: the CRC states and CRC logic are absent; after the last data byte the block goes straight to DONE.

Test Plan:
- Full ROM send: txData=64'h2D00_0000_1234_5678, startIdx=0, byteCount=8, transceiver acks each byte -> sentDat sequence 78,56,34,12,00,00,00,2D; 8 transTrig pulses; cmdDone=1; bytesSent=8; sentDat returns to FF.
- Clamp: startIdx=6, byteCount=5 -> exactly 2 bytes (00,2D) sent; bytesSent=2; cmdDone=1.
- Zero length / out of range: startIdx=7, byteCount=0, and separately startIdx=... with IDX_W=4, DATA_BYTES=8, startIdx=9 -> no transTrig (CRC off); cmdDone=1 within 3 clocks.
- CRC (macro on): txData=64'hA200_0000_01B8_1C02, startIdx=0, byteCount=7 -> bytes 02,1C,B8,01,00,00,00 then CRC byte A2; bytesSent=7.
- Abort after the 3rd ack -> no further transTrig, busy=0, cmdDone=0, bytesSent=3, sentDat=FF. A subsequent restart sends a full new sequence.
- Simultaneous events: cmdRunTrig edge coincident with ByteTransDone edge mid-command -> restart at the new startIdx, bytesSent=0. rst asserted mid-WAIT -> all outputs return to reset values next clock.
